// File: rtl/i2s_transmitter_pkg.sv
// ---------------------------------------------------------------------------
// i2s_transmitter_pkg
// Shared audio definitions used by the effects chain and the I2S output
// stage: the mono sample type, its default width and the I2S slot layout.
// ---------------------------------------------------------------------------
package i2s_transmitter_pkg;

    // Audio word width used across the effects chain.
    localparam int AUDIO_SAMPLE_BITS = 16;

    // Mono sample as produced by the effects chain (two's complement).
    typedef logic signed [AUDIO_SAMPLE_BITS-1:0] sample_t;

    // An I2S frame carries two slots: left then right.
    localparam int I2S_SLOTS = 2;

    // Divider counter width; large enough for CLK_DIV up to 255.
    localparam int DIV_CNT_W = 8;

    // Word-select encoding on lrclk.
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_channel_e;

    // Number of bit periods in one I2S frame.
    function automatic int frame_bits(input int sample_bits);
        return I2S_SLOTS * sample_bits;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// ---------------------------------------------------------------------------
// i2s_bclk_gen
// Divides clk down to the I2S bit clock. A counter runs 0..CLK_DIV-1 and
// bclk toggles on every wrap; the wrap that takes bclk from 1 to 0 is
// flagged on fall_event in the same cycle, so downstream logic updates its
// registers on the very edge where bclk falls.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   bclk       : I2S bit clock (registered)
//   fall_event : high for the clk cycle whose rising edge drives bclk 1->0
// ---------------------------------------------------------------------------
module i2s_bclk_gen
    import i2s_transmitter_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic fall_event
);

    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(CLK_DIV - 1);

    logic [DIV_CNT_W-1:0] div_cnt;
    logic                 wrap;

    assign wrap       = (div_cnt == DIV_LAST);
    assign fall_event = wrap && bclk;

    // NOTE: registers use non-blocking assignments so every flop samples the
    // values that existed before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + DIV_CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// ---------------------------------------------------------------------------
// i2s_transmitter
// Serialises a mono sample stream onto a standard I2S link. Each accepted
// sample is sent unmodified, MSB first, in both the left and right slot of
// one frame. A one-entry buffer decouples the producer from the frame
// timing; a frame that starts with nothing buffered is sent as silence and
// flagged on underrun.
//
// Frame timing: bit index 0..2*SAMPLE_BITS-1 advances on each bclk fall.
// Left slot is index 0..SAMPLE_BITS-1, right slot the rest. lrclk changes
// one bit period ahead of the slot it announces.
//
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   in_sample : signed mono sample from the effects chain
//   in_valid  : in_sample is valid
//   in_ready  : buffer is empty and a sample can be taken this cycle
//   bclk      : I2S bit clock
//   lrclk     : I2S word select, 0 = left, 1 = right
//   sdata     : I2S serial data, MSB first, changes on bclk falls only
//   underrun  : one-cycle pulse when a frame starts with the buffer empty
// ---------------------------------------------------------------------------
module i2s_transmitter
    import i2s_transmitter_pkg::*;
#(
    parameter int CLK_DIV     = 16,
    parameter int SAMPLE_BITS = AUDIO_SAMPLE_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [SAMPLE_BITS-1:0] in_sample,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic                          underrun
);

    localparam int FRAME_BITS = frame_bits(SAMPLE_BITS);
    localparam int IDX_W      = $clog2(FRAME_BITS);

    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(FRAME_BITS - 1);
    localparam logic [IDX_W-1:0] RIGHT_WS_IDX = IDX_W'(SAMPLE_BITS - 1);

    logic                          fall_event;
    logic                          frame_start;
    logic                          accept;
    logic [IDX_W-1:0]              bit_idx;
    logic [IDX_W-1:0]              next_idx;
    logic [FRAME_BITS-1:0]         shreg;
    logic signed [SAMPLE_BITS-1:0] hold_data;
    logic                          hold_full;
    i2s_channel_e                  ws;

    i2s_bclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk_gen (
        .clk        (clk),
        .rst        (rst),
        .bclk       (bclk),
        .fall_event (fall_event)
    );

    // Bit index after the next fall, wrapping at the end of the frame.
    // NOTE: the default assignment first means every path drives next_idx,
    // so no latch is inferred.
    always_comb begin
        next_idx = bit_idx + IDX_W'(1);
        if (bit_idx == LAST_IDX) begin
            next_idx = '0;
        end
    end

    assign frame_start = fall_event && (bit_idx == LAST_IDX);

    // in_ready is held low during reset even though the buffer is empty.
    assign in_ready = !hold_full && !rst;
    assign accept   = in_valid && in_ready;

    assign sdata = shreg[FRAME_BITS-1];
    assign lrclk = (ws == CH_RIGHT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx   <= LAST_IDX;
            ws        <= CH_LEFT;
            shreg     <= '0;
            hold_full <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;

            if (fall_event) begin
                bit_idx <= next_idx;

                // Word select leads the slot MSB by one bit period.
                if (next_idx == RIGHT_WS_IDX) begin
                    ws <= CH_RIGHT;
                end else if (next_idx == LAST_IDX) begin
                    ws <= CH_LEFT;
                end

                if (frame_start) begin
                    if (hold_full) begin
                        shreg <= {hold_data, hold_data};
                    end else begin
                        shreg    <= '0;
                        underrun <= 1'b1;
                    end
                end else begin
                    shreg <= shreg << 1;
                end
            end

            // accept implies the buffer was empty, so a coinciding frame
            // start has already loaded silence and the new sample waits for
            // the following frame.
            if (accept) begin
                hold_full <= 1'b1;
            end else if (frame_start) begin
                hold_full <= 1'b0;
            end
        end
    end

    // NOTE: the buffer data register is not reset; hold_full guards every
    // use of it, so its contents after reset are never observed.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_data <= in_sample;
        end
    end

endmodule
